// File: rtl/fpu_issue_ctrl_if.sv
// fpu_issue_ctrl_if: decode-side request and issue/writeback status bundle
// shared by the ID stage (master) and the FP issue controller (slave).
interface fpu_issue_ctrl_if;
  logic       id_fp_valid;
  logic [1:0] id_fp_class;
  logic [4:0] id_fd;
  logic [4:0] id_fs;
  logic [4:0] id_ft;
  logic       id_fs_used;
  logic       id_ft_used;
  logic       id_flush;
  logic       fp_stall;
  logic       fp_issue;
  logic [3:0] issue_unit;
  logic       wb_valid;
  logic [4:0] wb_fd;
  logic [3:0] wb_unit;
  logic       div_busy;

  modport master (
    output id_fp_valid, id_fp_class, id_fd, id_fs, id_ft,
           id_fs_used, id_ft_used, id_flush,
    input  fp_stall, fp_issue, issue_unit, wb_valid, wb_fd, wb_unit, div_busy
  );

  modport slave (
    input  id_fp_valid, id_fp_class, id_fd, id_fs, id_ft,
           id_fs_used, id_ft_used, id_flush,
    output fp_stall, fp_issue, issue_unit, wb_valid, wb_fd, wb_unit, div_busy
  );
endinterface

// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: issue scheduler for the pipelined FPU.
// Decides whether the FP op in ID may issue, tracks pending destinations in
// a 32-bit scoreboard, books the single regfile writeback port through a
// shifting reservation table and sequences the iterative divider.
// Optional feature: define FPU_WB_BYPASS_EN to treat a register retiring in
// the current cycle as no longer pending (the datapath forwards the value).
module fpu_issue_ctrl #(
  parameter int ADD_LAT = 2,
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 8
) (
  input  logic            clk,
  input  logic            reset,
  fpu_issue_ctrl_if.slave bus
);
  localparam int MAXLAT = DIV_LAT;
  localparam int LW     = $clog2(MAXLAT + 1);
  localparam int CW     = $clog2(DIV_LAT + 1);

  localparam logic [LW-1:0] LAT_SIMPLE = LW'(1);
  localparam logic [LW-1:0] LAT_ADD    = LW'(ADD_LAT);
  localparam logic [LW-1:0] LAT_MUL    = LW'(MUL_LAT);
  localparam logic [LW-1:0] LAT_DIV    = LW'(DIV_LAT);
  localparam logic [CW-1:0] DIV_CNT_INIT = CW'(DIV_LAT - 1);

  localparam logic [3:0] UNIT_SIMPLE = 4'b0001;
  localparam logic [3:0] UNIT_ADD    = 4'b0010;
  localparam logic [3:0] UNIT_MUL    = 4'b0100;
  localparam logic [3:0] UNIT_DIV    = 4'b1000;

  typedef struct packed {
    logic       v;
    logic [4:0] fd;
    logic [3:0] unit;
  } resv_t;

  typedef enum logic {DIV_IDLE, DIV_BUSY} div_state_t;

  resv_t         resv_reg   [MAXLAT];
  resv_t         resv_next  [MAXLAT];
  resv_t         resv_shift [MAXLAT];
  logic [MAXLAT:1] slot_busy;

  logic [31:0]   pend_reg, pend_next;
  logic [31:0]   pend_eff;
  logic [31:0]   wb_dec;

  div_state_t    div_state_reg, div_state_next;
  logic [CW-1:0] div_cnt_reg, div_cnt_next;

  logic [LW-1:0] op_lat;
  logic [3:0]    op_unit;
  logic          consider;
  logic          raw_haz, waw_haz, struct_haz, div_haz, any_haz;
  logic          issue;
  logic          div_start;

  // Latency and execution unit of the op sitting in ID
  always_comb begin
    op_lat  = LAT_SIMPLE;
    op_unit = UNIT_SIMPLE;
    case (bus.id_fp_class)
      2'd0:    begin op_lat = LAT_SIMPLE; op_unit = UNIT_SIMPLE; end
      2'd1:    begin op_lat = LAT_ADD;    op_unit = UNIT_ADD;    end
      2'd2:    begin op_lat = LAT_MUL;    op_unit = UNIT_MUL;    end
      default: begin op_lat = LAT_DIV;    op_unit = UNIT_DIV;    end
    endcase
  end

  // Each slot takes its upper neighbour; the top slot refills empty, which is
  // why a MAXLAT-latency op never meets a structural conflict.
  genvar gi;
  generate
    for (gi = 0; gi < MAXLAT; gi++) begin : g_resv
      if (gi == MAXLAT - 1) begin : g_top
        assign resv_shift[gi]  = '0;
        assign slot_busy[gi+1] = 1'b0;
      end else begin : g_mid
        assign resv_shift[gi]  = resv_reg[gi+1];
        assign slot_busy[gi+1] = resv_reg[gi+1].v;
      end
    end
  endgenerate

  // Writeback-retiring register decode, used to clear (and optionally bypass) the scoreboard
  assign wb_dec = resv_reg[0].v ? (32'd1 << resv_reg[0].fd) : 32'd0;

`ifdef FPU_WB_BYPASS_EN
  assign pend_eff = pend_reg & ~wb_dec;
`else
  assign pend_eff = pend_reg;
`endif

  // Hazard detection is only meaningful for a live, unflushed op out of reset
  assign consider   = reset & bus.id_fp_valid & ~bus.id_flush;
  assign raw_haz    = (pend_eff[bus.id_fs] & bus.id_fs_used) |
                      (pend_eff[bus.id_ft] & bus.id_ft_used);
  assign waw_haz    = pend_eff[bus.id_fd];
  assign struct_haz = slot_busy[op_lat];
  assign div_haz    = (bus.id_fp_class == 2'd3) & (div_state_reg == DIV_BUSY);
  assign any_haz    = raw_haz | waw_haz | struct_haz | div_haz;
  assign issue      = consider & ~any_haz;
  assign div_start  = issue & (bus.id_fp_class == 2'd3);

  assign bus.fp_stall   = consider & any_haz;
  assign bus.fp_issue   = issue;
  assign bus.issue_unit = issue ? op_unit : 4'b0000;

  assign bus.wb_valid = resv_reg[0].v;
  assign bus.wb_fd    = resv_reg[0].fd;
  assign bus.wb_unit  = resv_reg[0].unit;
  assign bus.div_busy = (div_state_reg == DIV_BUSY);

  // Next reservation table: shift toward slot 0, book slot L-1 for an issuing op
  always_comb begin
    for (int i = 0; i < MAXLAT; i++) begin
      resv_next[i] = resv_shift[i];
      if (issue && (op_lat == LW'(i + 1))) begin
        resv_next[i] = {1'b1, bus.id_fd, op_unit};
      end
    end
  end

  // Next scoreboard: retire the writeback register, a new issue wins on collision
  always_comb begin
    pend_next = pend_reg & ~wb_dec;
    if (issue) begin
      pend_next = pend_next | (32'd1 << bus.id_fd);
    end
  end

  // Reservation table and scoreboard registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < MAXLAT; i++) begin
        resv_reg[i] <= '0;
      end
      pend_reg <= '0;
    end else begin
      for (int i = 0; i < MAXLAT; i++) begin
        resv_reg[i] <= resv_next[i];
      end
      pend_reg <= pend_next;
    end
  end

  // Divider sequencer: busy for DIV_LAT-1 cycles after issue, so a new DIV
  // can issue in the same cycle the previous one writes back
  always_comb begin
    div_state_next = div_state_reg;
    div_cnt_next   = div_cnt_reg;
    case (div_state_reg)
      DIV_IDLE: begin
        if (div_start) begin
          div_cnt_next   = DIV_CNT_INIT;
          div_state_next = (DIV_CNT_INIT != '0) ? DIV_BUSY : DIV_IDLE;
        end
      end
      DIV_BUSY: begin
        div_cnt_next = div_cnt_reg - CW'(1);
        if (div_cnt_reg == CW'(1)) begin
          div_state_next = DIV_IDLE;
        end
      end
      default: begin
        div_state_next = DIV_IDLE;
        div_cnt_next   = '0;
      end
    endcase
  end

  // Divider state register
  always_ff @(posedge clk) begin
    if (!reset) begin
      div_state_reg <= DIV_IDLE;
      div_cnt_reg   <= '0;
    end else begin
      div_state_reg <= div_state_next;
      div_cnt_reg   <= div_cnt_next;
    end
  end
endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// tb_fpu_issue_ctrl: directed bench for fpu_issue_ctrl with a cycle-indexed
// reference model (writebacks booked by absolute cycle number, pending
// registers held as "retires at cycle N") checked every cycle on the falling
// edge, plus literal issue/writeback timing expectations.
module tb_fpu_issue_ctrl;
  localparam int ADD_LAT = 2;
  localparam int MUL_LAT = 3;
  localparam int DIV_LAT = 8;
`ifdef FPU_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk;
  logic reset;
  int   cyc;
  int   n_cmp;
  int   n_bad;

  fpu_issue_ctrl_if bus();

  fpu_issue_ctrl #(
    .ADD_LAT(ADD_LAT),
    .MUL_LAT(MUL_LAT),
    .DIV_LAT(DIV_LAT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model state ----------------
  typedef struct packed {
    logic [4:0] fd;
    logic [3:0] unit;
  } wb_t;

  wb_t wb_at   [int];   // writeback booked for absolute cycle
  int  pend_wb [32];    // cycle in which the register retires
  int  div_last;        // cycle of the most recent DIV issue
  bit  known;           // DUT registers defined (a reset edge has occurred)
  int  wb_seen [int];   // observed DUT writebacks, for literal checks

  function automatic void chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, act, exp);
    end
  endfunction

  function automatic bit is_pend(input logic [4:0] r);
    if (BYP) return pend_wb[r] > cyc;
    return pend_wb[r] >= cyc;
  endfunction

  function automatic int wb_fd_at(input int c);
    if (wb_seen.exists(c)) return wb_seen[c];
    return -1;
  endfunction

  // Compare process: derive expected outputs from the rules, then advance the model
  always @(negedge clk) begin
    int lat;
    logic [3:0] unit;
    bit act, raw, waw, st, dv, busy, exp_stall, exp_issue, exp_wbv;
    case (bus.id_fp_class)
      2'd0:    begin lat = 1;       unit = 4'b0001; end
      2'd1:    begin lat = ADD_LAT; unit = 4'b0010; end
      2'd2:    begin lat = MUL_LAT; unit = 4'b0100; end
      default: begin lat = DIV_LAT; unit = 4'b1000; end
    endcase
    busy = (cyc > div_last) && (cyc < div_last + DIV_LAT);
    act  = (reset === 1'b1) && (bus.id_fp_valid === 1'b1) && (bus.id_flush === 1'b0);
    raw  = (bus.id_fs_used && is_pend(bus.id_fs)) || (bus.id_ft_used && is_pend(bus.id_ft));
    waw  = is_pend(bus.id_fd);
    st   = (lat < DIV_LAT) && wb_at.exists(cyc + lat);
    dv   = (bus.id_fp_class == 2'd3) && busy;
    exp_stall = act && (raw || waw || st || dv);
    exp_issue = act && !exp_stall;

    chk("fp_stall", int'(bus.fp_stall), int'(exp_stall));
    chk("fp_issue", int'(bus.fp_issue), int'(exp_issue));
    if (exp_issue) chk("issue_unit", int'(bus.issue_unit), int'(unit));
    if (known) begin
      exp_wbv = wb_at.exists(cyc);
      chk("wb_valid", int'(bus.wb_valid), int'(exp_wbv));
      if (exp_wbv) begin
        chk("wb_fd", int'(bus.wb_fd), int'(wb_at[cyc].fd));
        chk("wb_unit", int'(bus.wb_unit), int'(wb_at[cyc].unit));
      end
      chk("div_busy", int'(bus.div_busy), int'(busy));
    end
    if (bus.wb_valid === 1'b1) wb_seen[cyc] = int'(bus.wb_fd);

    if (reset === 1'b0) begin
      wb_at.delete();
      for (int i = 0; i < 32; i++) pend_wb[i] = -1000;
      div_last = -1000;
      known = 1'b1;
    end else if (exp_issue) begin
      wb_at[cyc + lat] = '{fd: bus.id_fd, unit: unit};
      pend_wb[bus.id_fd] = cyc + lat;
      if (bus.id_fp_class == 2'd3) div_last = cyc;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle_inputs();
    bus.id_fp_valid = 1'b0;
    bus.id_fp_class = 2'd0;
    bus.id_fd       = 5'd0;
    bus.id_fs       = 5'd0;
    bus.id_ft       = 5'd0;
    bus.id_fs_used  = 1'b0;
    bus.id_ft_used  = 1'b0;
    bus.id_flush    = 1'b0;
  endtask

  task automatic present(input logic [1:0] cls, input logic [4:0] fd, input logic [4:0] fs,
                         input logic [4:0] ft, input logic fsu, input logic ftu);
    bus.id_fp_valid = 1'b1;
    bus.id_fp_class = cls;
    bus.id_fd       = fd;
    bus.id_fs       = fs;
    bus.id_ft       = ft;
    bus.id_fs_used  = fsu;
    bus.id_ft_used  = ftu;
    bus.id_flush    = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold an op in ID until it issues (bounded); returns in the following cycle
  task automatic issue_op(input logic [1:0] cls, input logic [4:0] fd, input logic [4:0] fs,
                          input logic [4:0] ft, input logic fsu, input logic ftu, output int ic);
    present(cls, fd, fs, ft, fsu, ftu);
    ic = -1;
    for (int k = 0; k < 40 && ic < 0; k++) begin
      @(negedge clk);
      if (bus.fp_issue === 1'b1) ic = cyc;
      @(posedge clk);
      #1;
    end
    idle_inputs();
    if (ic < 0) chk("issue_timeout", ic, 0);
    else $display("issue class=%0d fd=%0d at cycle %0d", cls, fd, ic);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int rel, t0, t1, ic, p, cnt;
    n_cmp    = 0;
    n_bad    = 0;
    known    = 1'b0;
    div_last = -1000;
    for (int i = 0; i < 32; i++) pend_wb[i] = -1000;
    reset = 1'b0;
    idle_inputs();

    // Reset held low with an op in ID: nothing issues, outputs cleared
    present(2'd1, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("rst_issue", int'(bus.fp_issue), 0);
    chk("rst_wb_valid", int'(bus.wb_valid), 0);
    chk("rst_div_busy", int'(bus.div_busy), 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    rel = cyc;
    issue_op(2'd1, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0, ic);
    chk("rst_release_issue", ic, rel);
    wait_cycles(12);

    // RAW: ABS $f2 then ADD $f4,$f2,$f6
    issue_op(2'd0, 5'd2, 5'd0, 5'd0, 1'b0, 1'b0, t0);
    issue_op(2'd1, 5'd4, 5'd2, 5'd6, 1'b1, 1'b1, t1);
    chk("raw_issue_gap", t1 - t0, BYP ? 1 : 2);
    chk("raw_wb_fd", wb_fd_at(t0 + 1), 2);
    wait_cycles(12);

    // STRUCT: MUL $f8 at c0, ABS $f10 presented in c2
    issue_op(2'd2, 5'd8, 5'd0, 5'd0, 1'b0, 1'b0, t0);
    wait_cycles(1);
    issue_op(2'd0, 5'd10, 5'd0, 5'd0, 1'b0, 1'b0, t1);
    chk("struct_issue_gap", t1 - t0, 3);
    wait_cycles(12);
    chk("struct_wb_mul", wb_fd_at(t0 + 3), 8);
    chk("struct_wb_abs", wb_fd_at(t0 + 4), 10);

    // DIV back to back
    issue_op(2'd3, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0, t0);
    issue_op(2'd3, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0, t1);
    chk("div_issue_gap", t1 - t0, 8);
    wait_cycles(12);
    chk("div_wb_first", wb_fd_at(t0 + 8), 1);
    chk("div_wb_second", wb_fd_at(t0 + 16), 3);

    // WAW: ADD $f5 then MUL $f5
    issue_op(2'd1, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0, t0);
    issue_op(2'd2, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0, t1);
    chk("waw_issue_gap", t1 - t0, BYP ? 2 : 3);
    wait_cycles(12);

    // Flush a stalled DIV; the issued one still writes back
    issue_op(2'd3, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0, t0);
    present(2'd3, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk("flush_pre_stall", int'(bus.fp_stall), 1);
    @(posedge clk);
    #1;
    bus.id_flush = 1'b1;
    @(negedge clk);
    chk("flush_stall", int'(bus.fp_stall), 0);
    chk("flush_issue", int'(bus.fp_issue), 0);
    @(posedge clk);
    #1;
    idle_inputs();
    p = cyc;
    issue_op(2'd1, 5'd7, 5'd3, 5'd3, 1'b1, 1'b1, ic);
    chk("flush_no_pend", ic, p);
    chk("flush_follow_gap", ic - t0, 3);
    wait_cycles(12);
    chk("flush_div_wb", wb_fd_at(t0 + 8), 1);

    // Reset pulse at c3 drops an in-flight DIV
    issue_op(2'd3, 5'd9, 5'd0, 5'd0, 1'b0, 1'b0, t0);
    wait_cycles(2);
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    wait_cycles(12);
    cnt = 0;
    for (int c = t0 + 1; c <= t0 + 15; c++) if (wb_seen.exists(c)) cnt++;
    chk("rst_pulse_no_wb", cnt, 0);
    chk("rst_pulse_div_busy", int'(bus.div_busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
